ex_cdb_queue: RTL and testbench

//  Parametrised multi-port completion queue between the execute units and writeback/CDB.

---
 rtl/ex_cdb_queue_pkg.sv | 28 ++
 rtl/ex_cdb_queue_if.sv | 39 +++
 rtl/ex_cdb_queue_input_compactor.sv | 35 +++
 rtl/ex_cdb_queue.sv | 135 +++++++++++++
 tb/tb_ex_cdb_queue.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_cdb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_cdb_queue_pkg
// Brief    : Shared packet type and default sizing for the EX->CDB queue.
// Revision : 1.0
// ============================================================================
package ex_cdb_queue_pkg;

    localparam int c_CDBQ_NUM_IN  = 3;
    localparam int c_CDBQ_NUM_OUT = 1;
    localparam int c_CDBQ_DEPTH   = 8;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] npc;
        logic [5:0]  dest_prn;
        logic [4:0]  rob_idx;
        logic        take_branch;
        logic        halt;
    } EX_PACKET;

    // Index width that stays legal when only one element exists.
    function automatic int f_clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_cdb_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_cdb_queue_if
// Brief    : Producer/consumer bundle for the EX->CDB completion queue.
// Revision : 1.0
// ============================================================================
interface ex_cdb_queue_if
    import ex_cdb_queue_pkg::*;
#(
    parameter int NUM_IN  = c_CDBQ_NUM_IN,
    parameter int NUM_OUT = c_CDBQ_NUM_OUT,
    parameter int DEPTH   = c_CDBQ_DEPTH
) ();

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               flush;
    EX_PACKET           in_packet  [NUM_IN];
    logic [NUM_IN-1:0]  in_valid;
    logic               in_ready;
    EX_PACKET           out_packet [NUM_OUT];
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic [CNT_W-1:0]   count;
    logic               empty;
    logic               full;

    modport master (
        output flush, in_packet, in_valid, out_ready,
        input  in_ready, out_packet, out_valid, count, empty, full
    );

    modport slave (
        input  flush, in_packet, in_valid, out_ready,
        output in_ready, out_packet, out_valid, count, empty, full
    );

endinterface
`default_nettype wire

// File: rtl/ex_cdb_queue_input_compactor.sv
`default_nettype none
// ============================================================================
// Module   : ex_cdb_queue_input_compactor
// Brief    : Turns a valid mask into an ordered list of set indices + count.
// Revision : 1.0
// ============================================================================
module ex_cdb_queue_input_compactor #(
    parameter int NUM_IN = 3,
    parameter int IDX_W  = 2,
    parameter int ACC_W  = 2
) (
    input  wire logic [NUM_IN-1:0] i_valid,
    output logic      [IDX_W-1:0]  o_idx [NUM_IN],
    output logic      [ACC_W-1:0]  o_n_acc
);

    logic [ACC_W-1:0] w_cnt;

    // Running prefix count selects the output slot for each set bit.
    always_comb begin
        for (int j = 0; j < NUM_IN; j++) begin
            o_idx[j] = '0;
        end
        w_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (i_valid[i]) begin
                o_idx[w_cnt] = IDX_W'(i);
                w_cnt        = w_cnt + ACC_W'(1);
            end
        end
        o_n_acc = w_cnt;
    end

endmodule
`default_nettype wire

// File: rtl/ex_cdb_queue.sv
`default_nettype none
// ============================================================================
// Module   : ex_cdb_queue
// Brief    : Multi-port age-ordered completion queue between EX and the CDB.
// Revision : 1.0
// ============================================================================
module ex_cdb_queue
    import ex_cdb_queue_pkg::*;
#(
    parameter int NUM_IN  = c_CDBQ_NUM_IN,
    parameter int NUM_OUT = c_CDBQ_NUM_OUT,
    parameter int DEPTH   = c_CDBQ_DEPTH
) (
    input  wire logic     clock,
    input  wire logic     reset,
    ex_cdb_queue_if.slave cdb
`ifdef DEBUG
    ,
    output EX_PACKET                           dbg_storage [DEPTH],
    output logic [f_clog2_min1(DEPTH)-1:0]     dbg_head,
    output logic [$clog2(DEPTH+1)-1:0]         dbg_count
`endif
);

    localparam int PTR_W = f_clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = f_clog2_min1(NUM_IN);
    localparam int ACC_W = $clog2(NUM_IN + 1);

    EX_PACKET           r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_live;
    logic               w_in_ready;
    logic [NUM_IN-1:0]  w_acc_mask;
    logic [IDX_W-1:0]   w_idx [NUM_IN];
    logic [ACC_W-1:0]   w_n_acc;
    logic [NUM_OUT-1:0] w_out_valid;
    EX_PACKET           w_out_pkt [NUM_OUT];
    logic               w_run;
    int                 w_pops;
    int                 w_head_adv;
    int                 w_skip;

    function automatic logic [PTR_W-1:0] f_wrap(input int v);
        return PTR_W'(v % DEPTH);
    endfunction

    // Nothing moves while reset is held or a flush squashes the cycle.
    assign w_live     = reset & ~cdb.flush;
    assign w_in_ready = (DEPTH - int'(r_count)) >= NUM_IN;
    assign w_acc_mask = cdb.in_valid & {NUM_IN{w_in_ready & w_live}};

    ex_cdb_queue_input_compactor #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W),
        .ACC_W  (ACC_W)
    ) u_compactor (
        .i_valid (w_acc_mask),
        .o_idx   (w_idx),
        .o_n_acc (w_n_acc)
    );

    // Virtual stream: stored entries first, then this cycle's accepted inputs.
    always_comb begin
        w_out_valid = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            w_out_pkt[k] = '0;
            if (w_live && (k < int'(r_count) + int'(w_n_acc))) begin
                w_out_valid[k] = 1'b1;
                if (k < int'(r_count)) begin
                    w_out_pkt[k] = r_mem[f_wrap(int'(r_head) + k)];
                end else begin
                    w_out_pkt[k] = cdb.in_packet[w_idx[k - int'(r_count)]];
                end
            end
        end
    end

    // Only a contiguous run from channel 0 may pop, preserving age order.
    always_comb begin
        w_run  = 1'b1;
        w_pops = 0;
        for (int k = 0; k < NUM_OUT; k++) begin
            w_run = w_run & w_out_valid[k] & cdb.out_ready[k];
            if (w_run) begin
                w_pops = w_pops + 1;
            end
        end
        w_head_adv = (w_pops < int'(r_count)) ? w_pops : int'(r_count);
        w_skip     = (w_pops > int'(r_count)) ? (w_pops - int'(r_count)) : 0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (cdb.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= f_wrap(int'(r_head) + w_head_adv);
            r_tail  <= f_wrap(int'(r_tail) + int'(w_n_acc) - w_skip);
            r_count <= CNT_W'(int'(r_count) + int'(w_n_acc) - w_pops);
        end
    end

    // Inputs already consumed by bypass are skipped; the rest land at tail.
    always_ff @(posedge clock) begin
        for (int j = 0; j < NUM_IN; j++) begin
            if ((j >= w_skip) && (j < int'(w_n_acc))) begin
                r_mem[f_wrap(int'(r_tail) + j - w_skip)] <= cdb.in_packet[w_idx[j]];
            end
        end
    end

    assign cdb.in_ready   = w_in_ready;
    assign cdb.out_valid  = w_out_valid;
    assign cdb.out_packet = w_out_pkt;
    assign cdb.count      = r_count;
    assign cdb.empty      = (r_count == '0);
    assign cdb.full       = (r_count == CNT_W'(DEPTH));

`ifdef DEBUG
    assign dbg_storage = r_mem;
    assign dbg_head    = r_head;
    assign dbg_count   = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_cdb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_cdb_queue
// Brief    : Directed self-checking bench for ex_cdb_queue (3/1/8 and 3/2/8).
// Revision : 1.0
// ============================================================================
module tb_ex_cdb_queue;
    import ex_cdb_queue_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    int         sent;
    int         got;
    int         mcount;
    int         nacc;
    int         pop;
    logic [2:0] v;
    logic       exp_valid;

    ex_cdb_queue_if #(.NUM_IN(3), .NUM_OUT(1), .DEPTH(8)) q_if  ();
    ex_cdb_queue_if #(.NUM_IN(3), .NUM_OUT(2), .DEPTH(8)) q2_if ();

    ex_cdb_queue #(.NUM_IN(3), .NUM_OUT(1), .DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .cdb   (q_if.slave)
    );

    ex_cdb_queue #(.NUM_IN(3), .NUM_OUT(2), .DEPTH(8)) dut2 (
        .clock (clock),
        .reset (reset),
        .cdb   (q2_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] vm, input int a0, input int a1, input int a2);
        q_if.in_valid = vm;
        for (int i = 0; i < 3; i++) q_if.in_packet[i] = '0;
        q_if.in_packet[0].alu_result = 32'(a0);
        q_if.in_packet[1].alu_result = 32'(a1);
        q_if.in_packet[2].alu_result = 32'(a2);
    endtask

    task automatic push2(input logic [2:0] vm, input int a0, input int a1, input int a2);
        q2_if.in_valid = vm;
        for (int i = 0; i < 3; i++) q2_if.in_packet[i] = '0;
        q2_if.in_packet[0].alu_result = 32'(a0);
        q2_if.in_packet[1].alu_result = 32'(a1);
        q2_if.in_packet[2].alu_result = 32'(a2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b0;
        q_if.flush      = 1'b0;
        q_if.out_ready  = '0;
        q2_if.flush     = 1'b0;
        q2_if.out_ready = '0;
        push(3'b000, 0, 0, 0);
        push2(3'b000, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(q_if.out_valid), 32'd0);
        chk("rst_empty",     32'(q_if.empty),     32'd1);
        chk("rst_count",     32'(q_if.count),     32'd0);
        chk("rst_in_ready",  32'(q_if.in_ready),  32'd1);
        chk("rst_full",      32'(q_if.full),      32'd0);

        // Zero-latency bypass of a single packet on channel 1
        @(negedge clock);
        push(3'b010, 0, 200, 0);
        q_if.out_ready = 1'b1;
        #1;
        chk("byp_valid", 32'(q_if.out_valid), 32'd1);
        chk("byp_alu",   q_if.out_packet[0].alu_result, 32'd200);
        @(negedge clock);
        push(3'b000, 0, 0, 0);
        #1;
        chk("byp_count", 32'(q_if.count),     32'd0);
        chk("byp_idle",  32'(q_if.out_valid), 32'd0);

        // Index-order draining of a full burst
        @(negedge clock);
        push(3'b111, 300, 400, 500);
        #1;
        chk("ord_alu0", q_if.out_packet[0].alu_result, 32'd300);
        @(negedge clock);
        push(3'b000, 0, 0, 0);
        #1;
        chk("ord_count2", 32'(q_if.count), 32'd2);
        chk("ord_alu1",   q_if.out_packet[0].alu_result, 32'd400);
        @(negedge clock);
        #1;
        chk("ord_count1", 32'(q_if.count), 32'd1);
        chk("ord_alu2",   q_if.out_packet[0].alu_result, 32'd500);
        @(negedge clock);
        #1;
        chk("ord_valid0", 32'(q_if.out_valid), 32'd0);
        chk("ord_empty",  32'(q_if.empty),     32'd1);

        // Backpressure up to full, then drain with wrap
        @(negedge clock);
        q_if.out_ready = 1'b0;
        push(3'b111, 10, 11, 12);
        #1;
        chk("bp_rdy0", 32'(q_if.in_ready), 32'd1);
        @(negedge clock);
        push(3'b111, 13, 14, 15);
        #1;
        chk("bp_count3", 32'(q_if.count), 32'd3);
        @(negedge clock);
        push(3'b111, 16, 17, 18);
        #1;
        chk("bp_count6", 32'(q_if.count),    32'd6);
        chk("bp_rdy6",   32'(q_if.in_ready), 32'd0);
        chk("bp_full6",  32'(q_if.full),     32'd0);
        @(negedge clock);
        #1;
        chk("bp_held", 32'(q_if.count), 32'd6);
        q_if.out_ready = 1'b1;
        #1;
        chk("bp_head", q_if.out_packet[0].alu_result, 32'd10);
        @(negedge clock);
        q_if.out_ready = 1'b0;
        #1;
        chk("bp_count5", 32'(q_if.count),    32'd5);
        chk("bp_rdy5",   32'(q_if.in_ready), 32'd1);
        @(negedge clock);
        push(3'b000, 0, 0, 0);
        #1;
        chk("bp_count8", 32'(q_if.count),    32'd8);
        chk("bp_full8",  32'(q_if.full),     32'd1);
        chk("bp_rdy8",   32'(q_if.in_ready), 32'd0);
        q_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("bp_drain", q_if.out_packet[0].alu_result, 32'(11 + i));
            @(negedge clock);
        end
        #1;
        chk("bp_empty", 32'(q_if.empty),     32'd1);
        chk("bp_valid", 32'(q_if.out_valid), 32'd0);
        q_if.out_ready = 1'b0;

        // Randomised valid/ready traffic; order must be exactly 1..40
        sent   = 1;
        got    = 1;
        mcount = 0;
        for (int cyc = 0; cyc < 400 && got <= 40; cyc++) begin
            @(negedge clock);
            v    = 3'($urandom_range(0, 7));
            nacc = 0;
            if (mcount > 5) v = 3'b000;
            for (int i = 0; i < 3; i++) q_if.in_packet[i] = '0;
            for (int i = 0; i < 3; i++) begin
                if (v[i] && (sent + nacc <= 40)) begin
                    q_if.in_packet[i].alu_result = 32'(sent + nacc);
                    nacc++;
                end else begin
                    v[i] = 1'b0;
                end
            end
            q_if.in_valid  = v;
            q_if.out_ready = 1'($urandom_range(0, 1));
            #1;
            exp_valid = (mcount + nacc) > 0;
            chk("rnd_count", 32'(q_if.count),     32'(mcount));
            chk("rnd_rdy",   32'(q_if.in_ready),  32'((8 - mcount) >= 3));
            chk("rnd_valid", 32'(q_if.out_valid), 32'(exp_valid));
            if (exp_valid) chk("rnd_order", q_if.out_packet[0].alu_result, 32'(got));
            pop    = (exp_valid && q_if.out_ready[0]) ? 1 : 0;
            mcount = mcount + nacc - pop;
            sent   = sent + nacc;
            got    = got + pop;
        end
        chk("rnd_done", 32'(got), 32'd41);
        @(negedge clock);
        push(3'b000, 0, 0, 0);
        q_if.out_ready = 1'b0;
        #1;
        chk("rnd_final", 32'(q_if.count), 32'd0);

        // Flush squashes the cycle and clears the queue
        @(negedge clock);
        push(3'b111, 50, 51, 52);
        @(negedge clock);
        push(3'b011, 53, 54, 0);
        @(negedge clock);
        push(3'b000, 0, 0, 0);
        #1;
        chk("fl_count5", 32'(q_if.count), 32'd5);
        q_if.flush     = 1'b1;
        q_if.out_ready = 1'b1;
        push(3'b111, 60, 61, 62);
        #1;
        chk("fl_valid", 32'(q_if.out_valid), 32'd0);
        @(negedge clock);
        q_if.flush     = 1'b0;
        q_if.out_ready = 1'b0;
        push(3'b000, 0, 0, 0);
        #1;
        chk("fl_count0", 32'(q_if.count), 32'd0);
        chk("fl_empty",  32'(q_if.empty), 32'd1);

        // Async reset in the middle of a cycle
        push(3'b111, 70, 71, 72);
        @(negedge clock);
        push(3'b001, 73, 0, 0);
        @(negedge clock);
        push(3'b111, 80, 81, 82);
        q_if.out_ready = 1'b1;
        #1;
        chk("ar_count4", 32'(q_if.count), 32'd4);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_count", 32'(q_if.count),     32'd0);
        chk("ar_valid", 32'(q_if.out_valid), 32'd0);
        chk("ar_rdy",   32'(q_if.in_ready),  32'd1);
        @(negedge clock);
        reset          = 1'b1;
        q_if.out_ready = 1'b0;
        push(3'b000, 0, 0, 0);

        // Two-output build: channel 1 cannot pop without channel 0
        @(negedge clock);
        push2(3'b111, 70, 71, 72);
        q2_if.out_ready = 2'b00;
        #1;
        chk("w2_valid", 32'(q2_if.out_valid), 32'd3);
        chk("w2_alu0",  q2_if.out_packet[0].alu_result, 32'd70);
        chk("w2_alu1",  q2_if.out_packet[1].alu_result, 32'd71);
        @(negedge clock);
        push2(3'b000, 0, 0, 0);
        q2_if.out_ready = 2'b10;
        #1;
        chk("w2_count3", 32'(q2_if.count), 32'd3);
        @(negedge clock);
        #1;
        chk("w2_nopop", 32'(q2_if.count), 32'd3);
        chk("w2_alu1b", q2_if.out_packet[1].alu_result, 32'd71);
        q2_if.out_ready = 2'b11;
        @(negedge clock);
        q2_if.out_ready = 2'b00;
        #1;
        chk("w2_count1", 32'(q2_if.count),     32'd1);
        chk("w2_valid1", 32'(q2_if.out_valid), 32'd1);
        chk("w2_alu2",   q2_if.out_packet[0].alu_result, 32'd72);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
